// File: rtl/imm_rot_encoder.sv
// Purpose : finds imm8/rot such that value == ROR(imm8, 2*rot) for the ARM
//           rotated-immediate operand format, or flags value as not encodable.
// Latency : first match at rotation r -> done r+2 cycles after start; no match -> 17 cycles.
// Backpr. : none; start is only accepted in IDLE and ignored while busy.
// Ports   : clk, reset (async active-low), start/value request in;
//           busy, done pulse, valid, imm8, rot, Src2 = {rot, imm8} out.
module imm_rot_encoder #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 8,
  parameter int ROT_W  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [DATA_W-1:0]        value,
  output logic                     busy,
  output logic                     done,
  output logic                     valid,
  output logic [IMM_W-1:0]         imm8,
  output logic [ROT_W-1:0]         rot,
  output logic [IMM_W+ROT_W-1:0]   Src2
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam logic [ROT_W-1:0] R_LAST = '1;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   work_q,  work_d;
  logic [ROT_W-1:0]    r_q,     r_d;
  logic                valid_q, valid_d;
  logic [IMM_W-1:0]    imm8_q,  imm8_d;
  logic [ROT_W-1:0]    rot_q,   rot_d;
  logic                fits;

  // work_q holds value rotated left by 2*r_q; a match means the rotated
  // word fits entirely in the immediate field.
  assign fits = (work_q[DATA_W-1:IMM_W] == '0);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      r_q     <= '0;
      valid_q <= 1'b0;
      imm8_q  <= '0;
      rot_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      r_q     <= r_d;
      valid_q <= valid_d;
      imm8_q  <= imm8_d;
      rot_q   <= rot_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    r_d     = r_q;
    valid_d = valid_q;
    imm8_d  = imm8_q;
    rot_d   = rot_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d  = value;
          r_d     = '0;
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        // Ascending search, so the smallest matching rotation wins.
        if (fits) begin
          imm8_d  = work_q[IMM_W-1:0];
          rot_d   = r_q;
          valid_d = 1'b1;
          state_d = S_DONE;
        end else if (r_q == R_LAST) begin
          imm8_d  = '0;
          rot_d   = '0;
          valid_d = 1'b0;
          state_d = S_DONE;
        end else begin
          work_d  = {work_q[DATA_W-3:0], work_q[DATA_W-1:DATA_W-2]};
          r_d     = r_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  assign valid = valid_q;
  assign imm8  = imm8_q;
  assign rot   = rot_q;
  assign Src2  = {rot_q, imm8_q};

endmodule
